// File: rtl/bob_except_retire.sv
// bob_except_retire: retire-side scanner of the per-bundle exception RAM.
// Accepts one bundle, reads its 10 slot records, and reports the lowest live
// excepting slot (or a clean result) through a valid/ready handshake.
module bob_except_retire #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    retire_valid,
  input  logic [5:0]              retire_addr,
  input  logic [9:0]              retire_mask,
  output logic                    retire_ready,
  output logic                    read_step,
  output logic [5:0]              read_addr,
  input  logic [DATA_WIDTH-1:0]   read_data0,
  input  logic [DATA_WIDTH-1:0]   read_data1,
  input  logic [DATA_WIDTH-1:0]   read_data2,
  input  logic [DATA_WIDTH-1:0]   read_data3,
  input  logic [DATA_WIDTH-1:0]   read_data4,
  input  logic [DATA_WIDTH-1:0]   read_data5,
  input  logic [DATA_WIDTH-1:0]   read_data6,
  input  logic [DATA_WIDTH-1:0]   read_data7,
  input  logic [DATA_WIDTH-1:0]   read_data8,
  input  logic [DATA_WIDTH-1:0]   read_data9,
  output logic                    done_valid,
  input  logic                    done_ready,
  output logic                    done_exc,
  output logic [3:0]              done_slot,
  output logic [DATA_WIDTH-2:0]   done_cause,
  output logic [5:0]              done_addr,
  input  logic                    flush
);

  localparam int unsigned NUM_SLOTS = 10;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned SLOT_W    = 4;
  localparam int unsigned CAUSE_W   = DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  state_t                 state_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [NUM_SLOTS-1:0]   mask_q;
  logic                   done_valid_q;
  logic                   done_exc_q;
  logic [SLOT_W-1:0]      done_slot_q;
  logic [CAUSE_W-1:0]     done_cause_q;
  logic [ADDR_W-1:0]      done_addr_q;

  logic [DATA_WIDTH-1:0]  rec [NUM_SLOTS];
  logic                   accept;
  logic                   hit_exc_d;
  logic [SLOT_W-1:0]      hit_slot_d;
  logic [CAUSE_W-1:0]     hit_cause_d;

  assign rec[0] = read_data0;
  assign rec[1] = read_data1;
  assign rec[2] = read_data2;
  assign rec[3] = read_data3;
  assign rec[4] = read_data4;
  assign rec[5] = read_data5;
  assign rec[6] = read_data6;
  assign rec[7] = read_data7;
  assign rec[8] = read_data8;
  assign rec[9] = read_data9;

  // Handshake and RAM read-port drive; a flush cycle never accepts.
  assign retire_ready = !flush && ((state_q == ST_IDLE) ||
                                   ((state_q == ST_REPORT) && done_ready));
  assign accept       = retire_valid && retire_ready;
  assign read_step    = accept;
  assign read_addr    = retire_addr;

  assign done_valid = done_valid_q;
  assign done_exc   = done_exc_q;
  assign done_slot  = done_slot_q;
  assign done_cause = done_cause_q;
  assign done_addr  = done_addr_q;

  // Priority encoder: scanning high to low leaves the lowest live hit in place.
  always_comb begin
    hit_exc_d   = 1'b0;
    hit_slot_d  = '0;
    hit_cause_d = '0;
    for (int k = int'(NUM_SLOTS) - 1; k >= 0; k--) begin
      if (mask_q[k] && rec[k][0]) begin
        hit_exc_d   = 1'b1;
        hit_slot_d  = SLOT_W'(k);
        hit_cause_d = rec[k][DATA_WIDTH-1:1];
      end
    end
  end

  // Control FSM with registered result outputs; flush overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      mask_q       <= '0;
      done_valid_q <= 1'b0;
      done_exc_q   <= 1'b0;
      done_slot_q  <= '0;
      done_cause_q <= '0;
      done_addr_q  <= '0;
    end else if (flush) begin
      state_q      <= ST_IDLE;
      done_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q  <= retire_addr;
            mask_q  <= retire_mask;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          done_valid_q <= 1'b1;
          done_exc_q   <= hit_exc_d;
          done_slot_q  <= hit_slot_d;
          done_cause_q <= hit_cause_d;
          done_addr_q  <= addr_q;
          state_q      <= ST_REPORT;
        end
        ST_REPORT: begin
          if (done_ready) begin
            done_valid_q <= 1'b0;
            if (accept) begin
              addr_q  <= retire_addr;
              mask_q  <= retire_mask;
              state_q <= ST_READ;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          done_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
